// File: rtl/mp_pkg.sv
// Shared types for the matching pursuit result read-back path.
// Default sizes, drain FSM states and the coefficient bundle.
package mp_pkg;

  localparam int MP_N_ATOMS    = 16;
  localparam int MP_DATA_WIDTH = 16;
  localparam int MP_IDX_WIDTH  = $clog2(MP_N_ATOMS);

  typedef enum logic [2:0] {
    IDLE,
    READ,
    CAPTURE,
    EVAL,
    FLUSH,
    WAIT_LAST,
    ACK
  } mp_state_e;

  typedef struct packed {
    logic [MP_IDX_WIDTH-1:0]         index;
    logic signed [MP_DATA_WIDTH-1:0] value;
    logic                            last;
  } mp_coef_t;

endpackage

// File: rtl/mp_stream_reg.sv
// Single-entry stream output register with valid/ready hold.
// Payload only changes on load, so it is stable while stalled.
module mp_stream_reg #(
  parameter int W = 21
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         load_i,
  input  logic [W-1:0] data_i,
  input  logic         ready_i,
  output logic         valid_o,
  output logic [W-1:0] data_o
);

  logic         valid_q, valid_d;
  logic [W-1:0] data_q, data_d;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (load_i) begin
      valid_d = 1'b1;
      data_d  = data_i;
    end else if (ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/mp_result_reader.sv
// Drains the nonzero coefficients of a finished MP run onto a stream.
// One-entry lookahead lets the final beat be tagged last.
module mp_result_reader
  import mp_pkg::*;
#(
  parameter int N_ATOMS    = MP_N_ATOMS,
  parameter int DATA_WIDTH = MP_DATA_WIDTH,
  parameter int IDX_WIDTH  = $clog2(N_ATOMS)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  done_i,
  output logic                  ack_o,
  output logic                  rd_en_o,
  output logic [IDX_WIDTH-1:0]  rd_addr_o,
  input  logic [DATA_WIDTH-1:0] rd_data_i,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [IDX_WIDTH-1:0]  out_index,
  output logic [DATA_WIDTH-1:0] out_value,
  output logic                  out_last,
  output logic                  busy_o,
  output logic [IDX_WIDTH:0]    nz_count_o
);

  localparam int CW = IDX_WIDTH + 1;
  localparam logic [IDX_WIDTH-1:0] LAST_ADDR = IDX_WIDTH'(N_ATOMS - 1);

  // Same layout as mp_coef_t, resized to the instance parameters.
  typedef struct packed {
    logic [IDX_WIDTH-1:0]         index;
    logic signed [DATA_WIDTH-1:0] value;
    logic                         last;
  } coef_t;

  mp_state_e            state_q, state_d;
  logic [IDX_WIDTH-1:0] addr_q, addr_d;
  logic                 done_q;
  coef_t                cap_q, cap_d;
  coef_t                pend_q, pend_d;
  logic                 pend_vld_q, pend_vld_d;
  logic [CW-1:0]        nz_q, nz_d;
  logic                 ack_q;

  coef_t                out_d, out_w;
  logic [$bits(coef_t)-1:0] out_bits;
  logic                 out_vld, out_load, out_free;
  logic                 adv, nz_bump;

  assign out_free = !out_vld || out_ready;

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    cap_d      = cap_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    nz_d       = nz_q;
    out_d      = '0;
    out_load   = 1'b0;
    adv        = 1'b0;
    nz_bump    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (done_i && !done_q) begin
          addr_d  = '0;
          nz_d    = '0;
          state_d = READ;
        end
      end
      READ: state_d = CAPTURE;
      CAPTURE: begin
        cap_d.index = addr_q;
        cap_d.value = rd_data_i;
        cap_d.last  = 1'b0;
        state_d     = EVAL;
      end
      EVAL: begin
        if (cap_q.value == '0) begin
          adv = 1'b1;
        end else if (!pend_vld_q) begin
          pend_d     = cap_q;
          pend_vld_d = 1'b1;
          nz_bump    = 1'b1;
          adv        = 1'b1;
        end else if (out_free) begin
          out_load   = 1'b1;
          out_d      = pend_q;
          out_d.last = 1'b0;
          pend_d     = cap_q;
          nz_bump    = 1'b1;
          adv        = 1'b1;
        end
      end
      FLUSH: begin
        // An all-zero result still yields one terminating beat.
        if (out_free) begin
          out_load   = 1'b1;
          out_d      = pend_vld_q ? pend_q : '0;
          out_d.last = 1'b1;
          pend_d     = '0;
          pend_vld_d = 1'b0;
          state_d    = WAIT_LAST;
        end
      end
      WAIT_LAST: begin
        if (out_vld && out_ready) state_d = ACK;
      end
      ACK: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (adv) begin
      if (addr_q == LAST_ADDR) begin
        state_d = FLUSH;
      end else begin
        addr_d  = addr_q + IDX_WIDTH'(1);
        state_d = READ;
      end
    end
    if (nz_bump && (nz_q < CW'(N_ATOMS))) nz_d = nz_q + CW'(1);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      done_q     <= 1'b0;
      cap_q      <= '0;
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
      nz_q       <= '0;
      ack_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      done_q     <= done_i;
      cap_q      <= cap_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      nz_q       <= nz_d;
      ack_q      <= (state_q == ACK);
    end
  end

  mp_stream_reg #(
    .W($bits(coef_t))
  ) u_out (
    .clk_i  (clock),
    .rst_i  (reset),
    .load_i (out_load),
    .data_i (out_d),
    .ready_i(out_ready),
    .valid_o(out_vld),
    .data_o (out_bits)
  );

  assign out_w      = coef_t'(out_bits);
  assign out_valid  = out_vld;
  assign out_index  = out_w.index;
  assign out_value  = out_w.value;
  assign out_last   = out_w.last;
  assign rd_en_o    = (state_q == READ);
  assign rd_addr_o  = addr_q;
  assign ack_o      = ack_q;
  assign busy_o     = (state_q != IDLE);
  assign nz_count_o = nz_q;

endmodule

// File: tb/tb_mp_result_reader.sv
// Directed bench for mp_result_reader: 16-atom and 4-atom instances.
// Beats, ack timing, read sequence and reset abort against hand values.
module tb_mp_result_reader;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        done_i = 1'b0;
  logic        out_ready = 1'b1;
  logic        ack_o, rd_en_o, out_valid, out_last, busy_o;
  logic [3:0]  rd_addr_o, out_index;
  logic [15:0] rd_data_i, out_value;
  logic [4:0]  nz_count_o;
  logic [15:0] ram [16];

  logic        done4 = 1'b0;
  logic        ack4, rd_en4, valid4, last4, busy4;
  logic [1:0]  addr4, idx4;
  logic [15:0] rdata4, val4;
  logic [2:0]  nz4;
  logic [15:0] ram4 [4];

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int hold_err = 0;
  int ack4n = 0;
  bit tog = 1'b0;
  int ph = 0;
  logic [20:0] bq[$];
  logic [20:0] bq4[$];
  int tcyc[$];
  int ackc[$];
  int rdq[$];

  bit          p_v = 1'b0;
  bit          p_r = 1'b0;
  logic [20:0] p_b = '0;

  mp_result_reader dut (
    .clock(clock), .reset(reset), .done_i(done_i), .ack_o(ack_o),
    .rd_en_o(rd_en_o), .rd_addr_o(rd_addr_o), .rd_data_i(rd_data_i),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_index(out_index), .out_value(out_value), .out_last(out_last),
    .busy_o(busy_o), .nz_count_o(nz_count_o)
  );

  mp_result_reader #(.N_ATOMS(4)) dut4 (
    .clock(clock), .reset(reset), .done_i(done4), .ack_o(ack4),
    .rd_en_o(rd_en4), .rd_addr_o(addr4), .rd_data_i(rdata4),
    .out_valid(valid4), .out_ready(1'b1),
    .out_index(idx4), .out_value(val4), .out_last(last4),
    .busy_o(busy4), .nz_count_o(nz4)
  );

  always #5 clock = ~clock;

  // RAM data lives for one cycle only; junk otherwise.
  always @(posedge clock) begin
    rd_data_i <= rd_en_o ? ram[rd_addr_o] : 16'hA5A5;
    rdata4    <= rd_en4 ? ram4[addr4] : 16'h5A5A;
  end

  initial forever begin
    @(posedge clock);
    #1;
    if (tog) begin
      ph = (ph + 1) % 3;
      out_ready = (ph == 0);
    end
  end

  initial forever begin
    @(negedge clock);
    cyc++;
    if (reset) begin
      p_v = 1'b0;
    end else begin
      if (p_v && !p_r &&
          !(out_valid && {out_index, out_value, out_last} == p_b))
        hold_err++;
      if (out_valid && out_ready) begin
        bq.push_back({out_index, out_value, out_last});
        tcyc.push_back(cyc);
      end
      if (ack_o) ackc.push_back(cyc);
      if (rd_en_o) rdq.push_back(int'(rd_addr_o));
      if (valid4) bq4.push_back({2'b00, idx4, val4, last4});
      if (ack4) ack4n++;
      p_v = out_valid;
      p_r = out_ready;
      p_b = {out_index, out_value, out_last};
    end
  end

  function automatic logic [20:0] mk(int i, int v, bit l);
    return {4'(i), 16'(v), l};
  endfunction

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_beats(string tag, logic [20:0] act[$],
                           logic [20:0] e[$]);
    chk({tag, "_n"}, act.size(), e.size());
    for (int i = 0; i < e.size(); i++)
      if (i < act.size()) chk(tag, act[i], e[i]);
  endtask

  task automatic chk_rd(string tag);
    int bad = 0;
    if (rdq.size() != 16) bad++;
    foreach (rdq[i]) if (rdq[i] != i) bad++;
    chk(tag, bad, 0);
  endtask

  task automatic chk_lat(string tag);
    int lat = -1;
    if (ackc.size() > 0 && tcyc.size() > 0)
      lat = ackc[0] - tcyc[tcyc.size()-1];
    chk(tag, lat, 2);
  endtask

  task automatic clearq();
    bq.delete();
    tcyc.delete();
    ackc.delete();
    rdq.delete();
    hold_err = 0;
  endtask

  task automatic scan(int maxc, int hold);
    int n = 0;
    @(posedge clock);
    #1 done_i = 1'b1;
    while (ackc.size() == 0 && n < maxc) begin
      @(negedge clock);
      n++;
    end
    chk("ack_seen", ackc.size() > 0, 1);
    repeat (hold) @(posedge clock);
    @(posedge clock);
    #1 done_i = 1'b0;
    repeat (5) @(negedge clock);
  endtask

  logic [20:0] e2[$];

  initial begin
    int n;
    bit found;
    for (int i = 0; i < 16; i++) ram[i] = '0;
    for (int i = 0; i < 4; i++) ram4[i] = 16'(i + 1);
    e2 = '{mk(3, 5, 0), mk(7, -2, 0), mk(15, 100, 1)};

    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("rst_busy", busy_o, 0);
    chk("rst_outs", {ack_o, rd_en_o, out_valid, out_last, out_index,
                     out_value, nz_count_o, rd_addr_o}, 0);
    @(posedge clock);
    #1 reset = 1'b0;

    clearq();
    scan(500, 0);
    chk_beats("zero_beats", bq, '{mk(0, 0, 1)});
    chk("zero_ackn", ackc.size(), 1);
    chk("zero_nz", nz_count_o, 0);
    chk_lat("zero_acklat");
    chk_rd("zero_rd");
    chk("zero_busy", busy_o, 0);

    ram[3] = 16'd5;
    ram[7] = 16'hFFFE;
    ram[15] = 16'd100;
    clearq();
    scan(500, 0);
    chk_beats("t2_beats", bq, e2);
    chk("t2_ackn", ackc.size(), 1);
    chk_lat("t2_acklat");
    chk("t2_nz", nz_count_o, 3);

    @(negedge clock);
    tog = 1'b1;
    clearq();
    scan(1000, 0);
    chk_beats("t3_beats", bq, e2);
    chk("t3_hold", hold_err, 0);
    chk_rd("t3_rd");
    chk("t3_ackn", ackc.size(), 1);
    chk("t3_nz", nz_count_o, 3);
    @(negedge clock);
    tog = 1'b0;
    out_ready = 1'b1;

    for (int i = 0; i < 16; i++) ram[i] = '0;
    ram[0] = 16'hFFFF;
    clearq();
    scan(500, 20);
    chk_beats("t4_beats", bq, '{mk(0, -1, 1)});
    chk("t4_ackn", ackc.size(), 1);
    chk_rd("t4_rd");
    chk("t4_busy", busy_o, 0);
    chk("t4_nz", nz_count_o, 1);

    ram[0] = '0;
    ram[3] = 16'd5;
    ram[7] = 16'hFFFE;
    ram[15] = 16'd100;
    @(negedge clock);
    out_ready = 1'b0;
    clearq();
    @(posedge clock);
    #1 done_i = 1'b1;
    found = 1'b0;
    n = 0;
    while (!found && n < 300) begin
      @(negedge clock);
      n++;
      if (rd_en_o && rd_addr_o == 4'd9) found = 1'b1;
    end
    chk("t5_found", found, 1);
    chk("t5_inflight", out_valid, 1);
    chk("t5_nz_pre", nz_count_o, 2);
    reset = 1'b1;
    done_i = 1'b0;
    @(negedge clock);
    chk("t5_rd_en", rd_en_o, 0);
    chk("t5_outs", {ack_o, out_valid, out_last, out_index, out_value,
                    busy_o, nz_count_o, rd_addr_o}, 0);
    @(posedge clock);
    #1 reset = 1'b0;
    out_ready = 1'b1;
    repeat (10) @(negedge clock);
    chk("t5_noack", ackc.size(), 0);
    chk("t5_nobeat", bq.size(), 0);
    clearq();
    scan(500, 0);
    chk_beats("t5_beats", bq, e2);
    chk("t5_nz", nz_count_o, 3);
    chk_rd("t5_rd");

    @(posedge clock);
    #1 done4 = 1'b1;
    n = 0;
    while (ack4n == 0 && n < 300) begin
      @(negedge clock);
      n++;
    end
    chk("t6_ack_seen", ack4n > 0, 1);
    @(posedge clock);
    #1 done4 = 1'b0;
    repeat (5) @(negedge clock);
    chk_beats("t6_beats", bq4,
              '{mk(0, 1, 0), mk(1, 2, 0), mk(2, 3, 0), mk(3, 4, 1)});
    chk("t6_nz", nz4, 4);
    chk("t6_ackn", ack4n, 1);
    chk("t6_busy", busy4, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mp_result_reader.md
Name: mp_result_reader

Overview:
- Host-side drain engine for the matching pursuit chip's sparse result. It is the read-back counterpart of the I/O block that loads the signal vector into the chip.
- When the chip raises done, the block scans the chip's coefficient RAM across all atom addresses and skips zero coefficients.
- It emits each nonzero (index, value) pair on a valid/ready stream, marks the final beat with out_last, then pulses ack_o so the chip can drop done.

Parameters:
N_ATOMS, 16, dictionary size (number of coefficient addresses scanned).
DATA_WIDTH, 16, signed coefficient width.
IDX_WIDTH, $clog2(N_ATOMS), index/address width.

Ports:
clock  input  1  single system clock, all logic on posedge.
reset  input  1  synchronous, active-high reset.
done_i  input  1  chip finished; result RAM stable while high.
ack_o  output  1  one-cycle pulse after the last beat is accepted.
rd_en_o  output  1  coefficient RAM read strobe.
rd_addr_o  output  IDX_WIDTH  coefficient RAM address.
rd_data_i  input  DATA_WIDTH  signed RAM data, valid exactly 1 cycle after rd_en_o, not held.
out_valid  output  1  stream beat valid.
out_ready  input  1  downstream accept.
out_index  output  IDX_WIDTH  atom index of beat.
out_value  output  DATA_WIDTH  signed coefficient of beat.
out_last  output  1  final beat of this result set.
busy_o  output  1  high in any state other than IDLE.
nz_count_o  output  IDX_WIDTH+1  nonzero coefficients found in the current/last scan.

Behaviour:
- Reset: state=IDLE; all outputs 0; pending and capture registers empty; done_q=0; nz_count_o=0. Reset mid-scan aborts immediately: no ack_o, rd_en_o low the next cycle, and any in-flight beat is dropped.
- Trigger: done_q registers done_i. A scan starts only on a rising edge (done_i=1 and done_q=0) seen in IDLE. A level held high after ack_o never retriggers. nz_count_o clears at scan start.
- Registers: cap (captured rd_data_i plus its address), pend (one-entry lookahead holding the most recent nonzero), out (stream output register).
- Transfer rule: a beat transfers on out_valid && out_ready. While out_valid=1 and out_ready=0, out_index, out_value and out_last are held stable. "out free" means out_valid=0, or a transfer happens this cycle.
- States:
  - IDLE: on trigger, set addr=0 and go to READ.
  - READ: rd_en_o=1 and rd_addr_o=addr for one cycle, then go to CAPTURE.
  - CAPTURE: cap<=rd_data_i, then go to EVAL. rd_en_o=0.
  - EVAL, zero cap: discard it and advance.
  - EVAL, nonzero cap with pend empty: pend<=cap, nz_count_o+1, advance.
  - EVAL, nonzero cap with pend full and out free: out<=pend with last=0, pend<=cap, nz_count_o+1, advance.
  - EVAL, otherwise: stall in EVAL with cap held.
  - Advance: if addr==N_ATOMS-1 go to FLUSH, else addr+1 and go to READ.
  - FLUSH: when out free, out<=pend with last=1 and pend cleared. If pend is empty (all-zero result), out<= index 0, value 0, last=1. Then go to WAIT_LAST.
  - WAIT_LAST: when the last beat transfers, go to ACK.
  - ACK: ack_o=1 for exactly one cycle, then go to IDLE.
- Latency: with out_ready=1 throughout, each atom takes 3 cycles (READ, CAPTURE, EVAL). The first beat appears at most 3 cycles after the second nonzero is evaluated. ack_o is asserted 2 cycles after the last-beat transfer.
- Arithmetic: "nonzero" means any bit set in the two's-complement value; negative values pass unchanged. nz_count_o saturates at N_ATOMS.
- Ordering: beats are emitted in strictly ascending index order, and exactly one beat per set carries out_last=1.
- Ignored input: done_i falling mid-scan is ignored; the scan completes.

Decomposition:
- Shared package mp_pkg holds: N_ATOMS/DATA_WIDTH defaults, the state enum (IDLE, READ, CAPTURE, EVAL, FLUSH, WAIT_LAST, ACK), and a packed struct mp_coef_t {index, value, last} used for the cap, pend and out registers.
- One sub-module: mp_stream_reg, the single-entry output register with valid/ready hold semantics. It is reusable by the I/O loader.

Test Plan:
- All-zero RAM, out_ready=1, done rising edge -> exactly one beat (index 0, value 0, last=1); ack_o pulses once; nz_count_o=0.
- RAM {3:5, 7:-2, 15:100}, out_ready=1 -> beats (3,5,0), (7,-2,0), (15,100,1); ack_o 2 cycles after the last transfer; nz_count_o=3.
- Same RAM with out_ready toggling 1-of-3 cycles -> identical beat sequence; fields stable while stalled; no duplicate or lost beat; rd_en_o never issued while EVAL stalls.
- Single nonzero {0:-1} -> one beat (0,-1,1); ack_o once; done_i held high for 20 cycles afterwards -> no second scan, busy_o=0.
- reset asserted during READ of addr 9 -> next cycle all outputs 0, no ack_o. A new done_i rising edge then rescans from addr 0 with correct output.
- N_ATOMS=4, all nonzero {1,2,3,4}, out_ready=1 -> 4 beats, only the index-3 beat has last=1; nz_count_o=4.
